uart_tx_sched: RTL

- Transmit scheduler and configuration controller in front of the UART top-level transmit path.
- Shares the single UART transmitter between NREQ byte requesters using round-robin arbitration.
- Sequences each byte through a load/ready handshake.
- Applies frame-format and baud changes (eight, pen, ohel, baud) only between frames, followed by a settle interval.

---
 rtl/uart_tx_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler and between-frame config applier feeding one UART transmitter.
// Config changes are only committed when the transmitter is idle, then a settle gap holds off the next byte.
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int DW         = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  input  logic                 cfg_eight,
  input  logic                 cfg_pen,
  input  logic                 cfg_ohel,
  input  logic [3:0]           cfg_baud,
  output logic                 eight,
  output logic                 pen,
  output logic                 ohel,
  output logic [3:0]           baud,
  output logic                 cfg_pending,
  input  logic                 tx_rdy,
  output logic                 tx_load,
  output logic [DW-1:0]        tx_data,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, WAIT, APPLY, SETTLE} state_t;

  state_t            state_reg;
  logic [IW-1:0]     last_reg;
  logic [IW-1:0]     win_reg;
  logic [CW-1:0]     settle_reg;
  logic [NREQ-1:0]   grant_reg;
  logic              tx_load_reg;
  logic [DW-1:0]     tx_data_reg;
  logic              eight_reg;
  logic              pen_reg;
  logic              ohel_reg;
  logic [3:0]        baud_reg;

  logic [DW-1:0]     req_byte [NREQ];
  logic [IW:0]       scan_sum [NREQ];
  logic [IW-1:0]     scan_idx [NREQ];
  logic              win_valid;
  logic [IW-1:0]     win_idx;

  // scan_idx[k] is the k-th requester to consider, starting just after the last winner.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
      localparam logic [IW:0] OFFSET = (IW+1)'(gi + 1);
      assign req_byte[gi] = req_data[gi*DW +: DW];
      assign scan_sum[gi] = {1'b0, last_reg} + OFFSET;
      assign scan_idx[gi] = (scan_sum[gi] >= NREQ_W) ? IW'(scan_sum[gi] - NREQ_W)
                                                     : scan_sum[gi][IW-1:0];
    end
  endgenerate

  // Walk from the lowest priority down so the highest-priority hit is the one that sticks.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[scan_idx[k]]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  assign cfg_pending = {cfg_eight, cfg_pen, cfg_ohel, cfg_baud} != {eight_reg, pen_reg, ohel_reg, baud_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_reg    <= IW'(NREQ - 1);
      win_reg     <= '0;
      settle_reg  <= '0;
      grant_reg   <= '0;
      tx_load_reg <= 1'b0;
      tx_data_reg <= '0;
      eight_reg   <= 1'b0;
      pen_reg     <= 1'b0;
      ohel_reg    <= 1'b0;
      baud_reg    <= '0;
    end else begin
      grant_reg   <= '0;
      tx_load_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Config is committed on entry so the new format is visible for the whole APPLY cycle.
          if (cfg_pending && tx_rdy) begin
            state_reg <= APPLY;
            eight_reg <= cfg_eight;
            pen_reg   <= cfg_pen;
            ohel_reg  <= cfg_ohel;
            baud_reg  <= cfg_baud;
          end else if (win_valid && tx_rdy) begin
            state_reg   <= LOAD;
            win_reg     <= win_idx;
            tx_data_reg <= req_byte[win_idx];
            tx_load_reg <= 1'b1;
            grant_reg   <= NREQ'(1) << win_idx;
          end
        end
        LOAD: begin
          last_reg  <= win_reg;
          state_reg <= HOLD;
        end
        HOLD: state_reg <= WAIT;
        WAIT: begin
          if (tx_rdy) state_reg <= IDLE;
        end
        APPLY: begin
          settle_reg <= CW'(SETTLE_CYC - 1);
          state_reg  <= SETTLE;
        end
        SETTLE: begin
          if (settle_reg == '0) state_reg <= IDLE;
          else settle_reg <= settle_reg - CW'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant   = grant_reg;
  assign tx_load = tx_load_reg;
  assign tx_data = tx_data_reg;
  assign eight   = eight_reg;
  assign pen     = pen_reg;
  assign ohel    = ohel_reg;
  assign baud    = baud_reg;
  assign busy    = (state_reg != IDLE);

endmodule
